// File: rtl/fibonacci_checker.sv
// -----------------------------------------------------------------------------
// fibonacci_checker
//
// Receive-side checker for a Fibonacci generator stream (F0=1, F1=1,
// Fn=Fn-1+Fn-2). Beats arrive over a valid/ready handshake. The checker locks
// onto a 1,1 start pair, flags the first deviating term with a one-cycle error
// pulse, spends one cycle in ERR with din_ready low, and then waits for a fresh
// 1,1 pair to re-lock.
//
// Optional feature macro: FIB_CHK_OVERFLOW_EN
//   defined   : the expected term is computed one bit wider; a carry out of the
//               expected sum is a mismatch regardless of din and sets the
//               sticky overflow flag until reset.
//   undefined : comparison wraps modulo 2^DATA_WIDTH; overflow is tied to 0.
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   reset      in   synchronous, active-high reset
//   din_valid  in   beat present on din
//   din        in   sequence term (DATA_WIDTH bits)
//   din_ready  out  checker accepts a beat this cycle (low only in ERR)
//   match      out  one-cycle pulse: last accepted beat matched
//   error      out  one-cycle pulse: last accepted beat mismatched
//   locked     out  checker is tracking a sequence (TRACK state)
//   count      out  matched terms since last sync, saturating (CNT_WIDTH bits)
//   overflow   out  sticky expected-term overflow flag
// -----------------------------------------------------------------------------
module fibonacci_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic                  match,
    output logic                  error,
    output logic                  locked,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        TRACK = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] D_ONE   = DATA_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  C_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  C_MAX   = '1;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   prev_q;
    logic [DATA_WIDTH-1:0]   prev2_q;
    logic [CNT_WIDTH-1:0]    count_q;
    logic                    match_q;
    logic                    error_q;

    logic                    accept;
    logic [DATA_WIDTH-1:0]   exp_term;
    logic                    sum_carry;
    logic [CNT_WIDTH-1:0]    count_sat_d;

    assign din_ready = (state_q != ERR);
    assign accept    = din_valid && din_ready;

`ifdef FIB_CHK_OVERFLOW_EN
    // One extra bit so a carry out of the expected sum is visible.
    logic [DATA_WIDTH:0] exp_sum;
    logic                overflow_q;

    assign exp_sum   = {1'b0, prev_q} + {1'b0, prev2_q};
    assign exp_term  = exp_sum[DATA_WIDTH-1:0];
    assign sum_carry = exp_sum[DATA_WIDTH];
    assign overflow  = overflow_q;
`else
    // Wrapping comparison, matching a generator that wraps at 2^DATA_WIDTH.
    assign exp_term  = prev_q + prev2_q;
    assign sum_carry = 1'b0;
    assign overflow  = 1'b0;
`endif

    // Count holds at its maximum once saturated.
    assign count_sat_d = (count_q == C_MAX) ? count_q : count_q + C_ONE;

    // NOTE: every register below is written with <= so all of them update
    // together from the values seen before the edge; = here would let later
    // statements observe half-updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            prev2_q    <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
            error_q    <= 1'b0;
`ifdef FIB_CHK_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            match_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Anything other than F0 is dropped without a pulse.
                    if (accept && din == D_ONE) begin
                        state_q <= FIRST;
                        match_q <= 1'b1;
                        count_q <= C_ONE;
                    end
                end
                FIRST: begin
                    if (accept) begin
                        if (din == D_ONE) begin
                            state_q <= TRACK;
                            match_q <= 1'b1;
                            count_q <= count_sat_d;
                            prev_q  <= D_ONE;
                            prev2_q <= D_ONE;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                            count_q <= '0;
                        end
                    end
                end
                TRACK: begin
                    if (accept) begin
                        if (!sum_carry && din == exp_term) begin
                            match_q <= 1'b1;
                            count_q <= count_sat_d;
                            prev2_q <= prev_q;
                            prev_q  <= din;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                            count_q <= '0;
`ifdef FIB_CHK_OVERFLOW_EN
                            if (sum_carry) begin
                                overflow_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
                ERR: begin
                    // Single dead cycle; the mismatching beat is never reused.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign match  = match_q;
    assign error  = error_q;
    assign locked = (state_q == TRACK);
    assign count  = count_q;

endmodule
